// File: rtl/gesture_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gesture_pkg : shared types/constants for the gesture tracker       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package gesture_pkg;

  localparam int COORD_W = 10;
  localparam logic [31:0] NOT_FOUND = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/gesture_tracker_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gesture_tracker_if : centroid in / cursor+stamp out bundle         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface gesture_tracker_if;
  import gesture_pkg::*;

  logic               pos_valid;
  logic [31:0]        x_pos;
  logic [31:0]        y_pos;
  logic [COORD_W-1:0] cursor_x;
  logic [COORD_W-1:0] cursor_y;
  logic               cursor_valid;
  logic               dragging;
  logic               stamp_pulse;
  logic [COORD_W-1:0] stamp_x;
  logic [COORD_W-1:0] stamp_y;
  logic [1:0]         state;

  modport master (
    output pos_valid, x_pos, y_pos,
    input  cursor_x, cursor_y, cursor_valid, dragging,
    input  stamp_pulse, stamp_x, stamp_y, state
  );

  modport slave (
    input  pos_valid, x_pos, y_pos,
    output cursor_x, cursor_y, cursor_valid, dragging,
    output stamp_pulse, stamp_x, stamp_y, state
  );

endinterface
`default_nettype wire

// File: rtl/axis_filter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axis_filter : per-axis IIR cursor update and stillness detect      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module axis_filter
  import gesture_pkg::*;
#(
  parameter int MOVE_TH      = 8,
  parameter int SMOOTH_SHIFT = 2
) (
  input  logic [COORD_W-1:0] raw,
  input  logic [COORD_W-1:0] cursor,
  input  logic               load,
  input  logic               update,
  output logic [COORD_W-1:0] next_cursor,
  output logic               still_axis
);

  localparam logic [COORD_W:0] TH = MOVE_TH[COORD_W:0];

  logic signed [COORD_W:0] diff;
  logic signed [COORD_W:0] step;
  logic        [COORD_W:0] mag;

  always_comb begin
    diff = $signed({1'b0, raw}) - $signed({1'b0, cursor});
    step = diff >>> SMOOTH_SHIFT;
    mag  = diff[COORD_W] ? -diff : diff;
    still_axis = (mag <= TH);
    // The step never carries the cursor past raw, so modulo-2^10 add is exact.
    if (load)
      next_cursor = raw;
    else if (update)
      next_cursor = cursor + step[COORD_W-1:0];
    else
      next_cursor = cursor;
  end

endmodule
`default_nettype wire

// File: rtl/gesture_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gesture_tracker : presence debounce, cursor smoothing, dwell stamp |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module gesture_tracker
  import gesture_pkg::*;
#(
  parameter int ACQ_FRAMES   = 3,
  parameter int MISS_TOL     = 2,
  parameter int DWELL_FRAMES = 30,
  parameter int MOVE_TH      = 8,
  parameter int SMOOTH_SHIFT = 2,
  parameter int X_MAX        = 640,
  parameter int Y_MAX        = 480
) (
  input  logic              clk,
  input  logic              reset_n,
  gesture_tracker_if.slave  bus
);

  localparam logic [3:0] ACQ_N   = ACQ_FRAMES[3:0];
  localparam logic [3:0] MISS_N  = MISS_TOL[3:0];
  localparam logic [7:0] DWELL_N = DWELL_FRAMES[7:0];

  state_t             state_q, state_d;
  logic [3:0]         acq_cnt, acq_d, miss_cnt, miss_d;
  logic [7:0]         still_cnt, still_d;
  logic [COORD_W-1:0] cur_x, cur_y, nxt_x, nxt_y;
  logic [COORD_W-1:0] stamp_x_q, stamp_y_q, stamp_x_d, stamp_y_d;
  logic               stamp_q, stamp_d;
  logic               load, update, still_x, still_y, still, hit;

  assign hit   = (bus.x_pos < 32'(X_MAX)) && (bus.y_pos < 32'(Y_MAX));
  assign still = still_x && still_y;

  axis_filter #(.MOVE_TH(MOVE_TH), .SMOOTH_SHIFT(SMOOTH_SHIFT)) u_fx (
    .raw(bus.x_pos[COORD_W-1:0]), .cursor(cur_x), .load(load), .update(update),
    .next_cursor(nxt_x), .still_axis(still_x)
  );

  axis_filter #(.MOVE_TH(MOVE_TH), .SMOOTH_SHIFT(SMOOTH_SHIFT)) u_fy (
    .raw(bus.y_pos[COORD_W-1:0]), .cursor(cur_y), .load(load), .update(update),
    .next_cursor(nxt_y), .still_axis(still_y)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      acq_cnt   <= '0;
      miss_cnt  <= '0;
      still_cnt <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      stamp_q   <= 1'b0;
      stamp_x_q <= '0;
      stamp_y_q <= '0;
    end else begin
      state_q   <= state_d;
      acq_cnt   <= acq_d;
      miss_cnt  <= miss_d;
      still_cnt <= still_d;
      cur_x     <= nxt_x;
      cur_y     <= nxt_y;
      stamp_q   <= stamp_d;
      stamp_x_q <= stamp_x_d;
      stamp_y_q <= stamp_y_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acq_d     = acq_cnt;
    miss_d    = miss_cnt;
    still_d   = still_cnt;
    load      = 1'b0;
    update    = 1'b0;
    stamp_d   = 1'b0;
    stamp_x_d = stamp_x_q;
    stamp_y_d = stamp_y_q;
    if (bus.pos_valid) begin
      if (hit) begin
        case (state_q)
          ST_IDLE, ST_ACQUIRE: begin
            acq_d = (state_q == ST_IDLE) ? 4'd1 : acq_cnt + 4'd1;
            if (acq_d == ACQ_N) begin
              state_d = ST_TRACK;
              load    = 1'b1;
              still_d = '0;
              miss_d  = '0;
            end else begin
              state_d = ST_ACQUIRE;
            end
          end
          ST_TRACK: begin
            miss_d = '0;
            update = 1'b1;
            if (!still)
              still_d = '0;
            else if (still_cnt + 8'd1 >= DWELL_N) begin
              stamp_d   = 1'b1;
              stamp_x_d = nxt_x;
              stamp_y_d = nxt_y;
              state_d   = ST_HOLD;
              still_d   = '0;
            end else
              still_d = still_cnt + 8'd1;
          end
          default: begin
            miss_d = '0;
            update = 1'b1;
            if (!still) begin
              state_d = ST_TRACK;
              still_d = '0;
            end
          end
        endcase
      end else begin
        case (state_q)
          ST_ACQUIRE: begin
            state_d = ST_IDLE;
            acq_d   = '0;
          end
          ST_TRACK, ST_HOLD: begin
            miss_d = miss_cnt + 4'd1;
            if (miss_d >= MISS_N) begin
              state_d = ST_IDLE;
              acq_d   = '0;
              miss_d  = '0;
              still_d = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.cursor_x     = cur_x;
  assign bus.cursor_y     = cur_y;
  assign bus.cursor_valid = (state_q == ST_TRACK) || (state_q == ST_HOLD);
  assign bus.dragging     = (state_q == ST_TRACK);
  assign bus.stamp_pulse  = stamp_q;
  assign bus.stamp_x      = stamp_x_q;
  assign bus.stamp_y      = stamp_y_q;
  assign bus.state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_gesture_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_gesture_tracker : scoreboard bench against a behavioural model  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_gesture_tracker;
  import gesture_pkg::*;

  localparam int ACQ = 3, MISS = 2, DWELL = 30, MTH = 8, SH = 2, XM = 640, YM = 480;

  typedef struct {
    int st; int cx; int cy; int valid; int drag; int stamp; int sx; int sy;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  gesture_tracker_if bus();

  gesture_tracker #(
    .ACQ_FRAMES(ACQ), .MISS_TOL(MISS), .DWELL_FRAMES(DWELL), .MOVE_TH(MTH),
    .SMOOTH_SHIFT(SH), .X_MAX(XM), .Y_MAX(YM)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, n_stamps = 0;
  exp_t sb[$];
  int m_state, m_acq, m_miss, m_still, m_cx, m_cy, m_sx, m_sy, m_stamp;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Floor division by 2^SH, written independently of any shift operator.
  function automatic int smooth_step(input int d);
    int div = 1 << SH;
    return (d >= 0) ? d / div : -((-d + div - 1) / div);
  endfunction

  task automatic model_reset();
    m_state = 0; m_acq = 0; m_miss = 0; m_still = 0;
    m_cx = 0; m_cy = 0; m_sx = 0; m_sy = 0; m_stamp = 0;
  endtask

  task automatic model_frame(input logic [31:0] x, input logic [31:0] y);
    bit h = (x < XM) && (y < YM);
    int rx = int'(x[9:0]), ry = int'(y[9:0]);
    bit st;
    m_stamp = 0;
    if (h) begin
      if (m_state == 0 || m_state == 1) begin
        m_acq = (m_state == 0) ? 1 : m_acq + 1;
        if (m_acq == ACQ) begin
          m_state = 2; m_cx = rx; m_cy = ry; m_still = 0; m_miss = 0;
        end else m_state = 1;
      end else begin
        st = (iabs(rx - m_cx) <= MTH) && (iabs(ry - m_cy) <= MTH);
        m_cx = m_cx + smooth_step(rx - m_cx);
        m_cy = m_cy + smooth_step(ry - m_cy);
        m_miss = 0;
        if (m_state == 2) begin
          if (st) begin
            m_still++;
            if (m_still >= DWELL) begin
              m_stamp = 1; m_sx = m_cx; m_sy = m_cy; m_state = 3; m_still = 0;
            end
          end else m_still = 0;
        end else if (!st) begin
          m_state = 2; m_still = 0;
        end
      end
    end else begin
      if (m_state == 1) begin
        m_state = 0; m_acq = 0;
      end else if (m_state >= 2) begin
        m_miss++;
        if (m_miss >= MISS) begin
          m_state = 0; m_acq = 0; m_miss = 0; m_still = 0;
        end
      end
    end
  endtask

  task automatic drive_frame(input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    @(negedge clk);
    bus.pos_valid = 1'b1; bus.x_pos = x; bus.y_pos = y;
    model_frame(x, y);
    e = '{m_state, m_cx, m_cy, (m_state >= 2), (m_state == 2), m_stamp, m_sx, m_sy};
    sb.push_back(e);
    @(posedge clk); #1;
    bus.pos_valid = 1'b0;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("state", int'(bus.state), e.st);
      check("cursor_x", int'(bus.cursor_x), e.cx);
      check("cursor_y", int'(bus.cursor_y), e.cy);
      check("cursor_valid", int'(bus.cursor_valid), e.valid);
      check("dragging", int'(bus.dragging), e.drag);
      check("stamp_pulse", int'(bus.stamp_pulse), e.stamp);
      check("stamp_x", int'(bus.stamp_x), e.sx);
      check("stamp_y", int'(bus.stamp_y), e.sy);
    end
    if (bus.stamp_pulse) n_stamps++;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("stamp_clr", int'(bus.stamp_pulse), 0);
    check("hold_state", int'(bus.state), m_state);
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y);
    drive_frame(x, y);
    idle_cycle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.pos_valid = 1'b0; bus.x_pos = '0; bus.y_pos = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
  endtask

  initial begin
    int base;
    do_reset();
    #1;
    check("rst_state", int'(bus.state), 0);
    check("rst_valid", int'(bus.cursor_valid), 0);
    check("rst_drag", int'(bus.dragging), 0);
    check("rst_stamp", int'(bus.stamp_pulse), 0);
    check("rst_cx", int'(bus.cursor_x), 0);
    check("rst_sx", int'(bus.stamp_x), 0);

    // Acquire
    send(100, 200); send(100, 200);
    check("acq_not_yet", int'(bus.cursor_valid), 0);
    send(100, 200);
    check("acq_track", int'(bus.state), 2);
    check("acq_cx", int'(bus.cursor_x), 100);
    check("acq_cy", int'(bus.cursor_y), 200);

    // Smoothing
    send(108, 180);
    check("smooth_cx", int'(bus.cursor_x), 102);
    check("smooth_cy", int'(bus.cursor_y), 195);

    // Loss tolerance
    send(NOT_FOUND, NOT_FOUND);
    check("miss1_state", int'(bus.state), 2);
    check("miss1_cx", int'(bus.cursor_x), 102);
    send(102, 195);
    check("miss_recover", int'(bus.state), 2);
    send(NOT_FOUND, NOT_FOUND); send(NOT_FOUND, NOT_FOUND);
    check("lost_state", int'(bus.state), 0);
    check("lost_valid", int'(bus.cursor_valid), 0);
    check("lost_cx_kept", int'(bus.cursor_x), 102);

    // Acquire abort
    send(300, 300); send(300, 300); send(NOT_FOUND, NOT_FOUND);
    check("abort_state", int'(bus.state), 0);
    send(300, 300); send(300, 300);
    check("reacq_pending", int'(bus.state), 1);
    send(300, 300);
    check("reacq_track", int'(bus.state), 2);

    // Dwell stamp, then no re-stamp in HOLD
    base = n_stamps;
    for (int i = 0; i < DWELL; i++) send(300, 300);
    check("dwell_one_stamp", n_stamps - base, 1);
    check("dwell_hold", int'(bus.state), 3);
    check("dwell_sx", int'(bus.stamp_x), 300);
    check("dwell_sy", int'(bus.stamp_y), 300);
    for (int i = 0; i < 40; i++) send(300, 300);
    check("hold_no_restamp", n_stamps - base, 1);
    send(400, 300);
    check("jump_track", int'(bus.state), 2);
    check("jump_cx", int'(bus.cursor_x), 325);

    // Boundary values
    send(640, 100);
    check("x640_miss", int'(bus.state), 2);
    send(100, 480);
    check("y480_lost", int'(bus.state), 0);
    send(639, 479); send(639, 479); send(639, 479);
    check("edge_track", int'(bus.state), 2);
    check("edge_cx", int'(bus.cursor_x), 639);
    check("edge_cy", int'(bus.cursor_y), 479);

    // Reset during the stamp cycle
    for (int i = 0; i < DWELL - 1; i++) send(639, 479);
    drive_frame(639, 479);
    check("pre_rst_stamp", int'(bus.stamp_pulse), 1);
    reset_n = 1'b0;
    #1;
    check("rst_stamp_clr", int'(bus.stamp_pulse), 0);
    check("rst_idle", int'(bus.state), 0);
    check("rst_valid_clr", int'(bus.cursor_valid), 0);
    do_reset();
    send(10, 10);
    check("post_rst_acq", int'(bus.state), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
